// File: rtl/pixel_scan_seq_pkg.sv
// Shared types for the pixel sequencer and the framebuffer writer that follows it.
package pixel_scan_seq_pkg;

  // Screen coordinates are Q11.21 fixed point.
  localparam int FP_W_DEF    = 32;
  localparam int FP_FRAC_DEF = 21;

  typedef logic [FP_W_DEF-1:0] fp_t;

  // Frame-level scan state, also decoded by the framebuffer writer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_seq_credit_counter.sv
// Up/down credit counter saturating at MAX; a decrement at zero holds the
// count and raises a sticky underflow flag.
module credit_counter #(
  parameter int MAX = 16,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          err_underflow
);

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Next-state: simultaneous inc/dec cancel; saturate at both ends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    err_d   = err_q;
    unique case ({inc, dec})
      2'b10: if (count_q != CW'(MAX)) count_d = count_q + 1'b1;
      2'b01: begin
        if (count_q == '0) err_d   = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  // State registers; the underflow flag only clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count         = count_q;
  assign count_next    = count_d;
  assign err_underflow = err_q;

endmodule

// File: rtl/pixel_scan_seq.sv
// Raster-scan pixel coordinate sequencer: issues Q11.21 (x, y) beats on a
// valid/ready stream, throttled by returned-pixel credits.
module pixel_scan_seq
  import pixel_scan_seq_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int MAX_INFLIGHT = 16,
  parameter int FP_W         = FP_W_DEF,
  parameter int FP_FRAC      = FP_FRAC_DEF,
  localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            continuous,
  input  logic            abort,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] screen_x,
  output logic [FP_W-1:0] screen_y,
  output logic            sof,
  output logic            eol,
  input  logic            ret_valid,
  output logic            busy,
  output logic            frame_done,
  output logic [CW-1:0]   inflight,
  output logic [15:0]     frame_count,
  output logic            err_underflow
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic          frame_done_q, frame_done_d;
  logic [15:0]   frame_count_q, frame_count_d;

  logic          xfer;
  logic          last_pix;
  logic          credit_ok;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_next;

  assign xfer     = out_valid_q && out_ready;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  // Looking at next-cycle usage keeps out_valid high only while a credit is free.
  assign credit_ok = (inflight_next < CW'(MAX_INFLIGHT));

  credit_counter #(
    .MAX (MAX_INFLIGHT)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .inc           (xfer),
    .dec           (ret_valid),
    .count         (inflight_q),
    .count_next    (inflight_next),
    .err_underflow (err_underflow)
  );

  // Scan FSM next-state: raster advance, abort handling and drain/restart.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    out_valid_d   = out_valid_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          // A pending beat is dropped, not transferred.
          state_d     = ST_DRAIN;
          out_valid_d = 1'b0;
        end else if (xfer) begin
          if (last_pix) begin
            state_d     = ST_DRAIN;
            out_valid_d = 1'b0;
          end else begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            out_valid_d = credit_ok;
          end
        end else if (!out_valid_q) begin
          out_valid_d = credit_ok;
        end
      end
      ST_DRAIN: begin
        out_valid_d = 1'b0;
        if (frame_done_q) begin
          // Restart decision taken in the frame_done cycle, busy still high.
          state_d = continuous ? ST_SCAN : ST_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else if (inflight_q == '0) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sof_d = out_valid_d && (x_d == '0) && (y_d == '0);
    eol_d = out_valid_d && (x_d == X_LAST);
  end

  // Scan FSM registers; all outputs return to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      out_valid_q   <= 1'b0;
      sof_q         <= 1'b0;
      eol_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      out_valid_q   <= out_valid_d;
      sof_q         <= sof_d;
      eol_q         <= eol_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign sof         = sof_q;
  assign eol         = eol_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign inflight    = inflight_q;
  assign busy        = (state_q != ST_IDLE);
  assign screen_x    = FP_W'(x_q) << FP_FRAC;
  assign screen_y    = FP_W'(y_q) << FP_FRAC;

endmodule

// File: tb/tb_pixel_scan_seq.sv
// Directed bench for pixel_scan_seq on a 4x3 frame with two credits.
module tb_pixel_scan_seq;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int M   = 2;
  localparam int FPW = 32;
  localparam int FPF = 21;
  localparam int CW  = $clog2(M + 1);

  typedef struct packed {
    logic [FPW-1:0] sx;
    logic [FPW-1:0] sy;
    logic           sof;
    logic           eol;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic ret_man = 1'b0;
  logic auto_en = 1'b0;
  logic [4:0] ret_pipe = '0;

  logic           out_valid, sof, eol, busy, frame_done, err_underflow, ret_valid;
  logic [FPW-1:0] screen_x, screen_y;
  logic [CW-1:0]  inflight;
  logic [15:0]    frame_count;

  beat_t beats[$];
  beat_t cur, prev_beat;
  logic  prev_stall = 1'b0;
  int    done_pulses = 0;
  int    stall_errs = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign ret_valid = ret_man | ret_pipe[4];
  assign cur       = {screen_x, screen_y, sof, eol};

  pixel_scan_seq #(
    .H_RES        (H),
    .V_RES        (V),
    .MAX_INFLIGHT (M),
    .FP_W         (FPW),
    .FP_FRAC      (FPF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .continuous    (continuous),
    .abort         (abort),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .screen_x      (screen_x),
    .screen_y      (screen_y),
    .sof           (sof),
    .eol           (eol),
    .ret_valid     (ret_valid),
    .busy          (busy),
    .frame_done    (frame_done),
    .inflight      (inflight),
    .frame_count   (frame_count),
    .err_underflow (err_underflow)
  );

  // Monitor: logs transfers, frame_done pulses, stall stability; returns each
  // transfer five cycles later when auto_en is set.
  always @(posedge clk) begin
    if (rst) begin
      ret_pipe <= '0;
      beats.delete();
      done_pulses = 0;
      stall_errs  = 0;
      prev_stall  = 1'b0;
    end else begin
      ret_pipe <= {ret_pipe[3:0], out_valid & out_ready & auto_en};
      if (out_valid && out_ready) beats.push_back(cur);
      if (frame_done) done_pulses++;
      if (prev_stall && out_valid && (cur !== prev_beat)) stall_errs++;
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    out_ready = 1'b0; ret_man = 1'b0; auto_en = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cyc, input bit toggle);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (toggle) out_ready = ~out_ready;
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sof, eol, busy, frame_done, err_underflow} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {out_valid, sof, eol, busy, frame_done, err_underflow});
    end
    checks++;
    if (inflight !== '0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got inflight=%0d frames=%0d want 0 0", inflight, frame_count);
    end
    checks++;
    if (screen_x !== '0 || screen_y !== '0) begin
      errors++;
      $display("FAIL reset_coords got %h %h want 0 0", screen_x, screen_y);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    beat_t exp;
    do_reset();
    auto_en = 1'b1; out_ready = 1'b1;
    pulse_start();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency1 got valid=%b busy=%b want 0 1", out_valid, busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || sof !== 1'b1 || screen_x !== '0 || screen_y !== '0) begin
      errors++;
      $display("FAIL start_latency2 got valid=%b sof=%b x=%h y=%h want 1 1 0 0",
               out_valid, sof, screen_x, screen_y);
    end
    run_until_idle(300, 1'b0);
    checks++;
    if (beats.size() != H * V) begin
      errors++;
      $display("FAIL single_count got %0d want %0d", beats.size(), H * V);
    end
    for (int i = 0; i < beats.size(); i++) begin
      exp.sx  = 32'(i % H) << FPF;
      exp.sy  = 32'((i / H) % V) << FPF;
      exp.sof = (i % (H * V)) == 0;
      exp.eol = (i % H) == H - 1;
      checks++;
      if (beats[i] !== exp) begin
        errors++;
        $display("FAIL single_beat[%0d] got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 beats[i].sx, beats[i].sy, beats[i].sof, beats[i].eol,
                 exp.sx, exp.sy, exp.sof, exp.eol);
      end
    end
    if (beats.size() > 3) begin
      checks++;
      if (beats[3].sx !== 32'h0060_0000) begin
        errors++;
        $display("FAIL x3_value got %h want 00600000", beats[3].sx);
      end
    end
    checks++;
    if (done_pulses != 1 || frame_count !== 16'd1 || busy !== 1'b0 || inflight !== '0) begin
      errors++;
      $display("FAIL single_end got done=%0d frames=%0d busy=%b inflight=%0d want 1 1 0 0",
               done_pulses, frame_count, busy, inflight);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp;
    do_reset();
    auto_en = 1'b1; out_ready = 1'b1;
    pulse_start();
    run_until_idle(400, 1'b1);
    checks++;
    if (beats.size() != H * V) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", beats.size(), H * V);
    end
    for (int i = 0; i < beats.size(); i++) begin
      exp.sx  = 32'(i % H) << FPF;
      exp.sy  = 32'((i / H) % V) << FPF;
      exp.sof = (i % (H * V)) == 0;
      exp.eol = (i % H) == H - 1;
      checks++;
      if (beats[i] !== exp) begin
        errors++;
        $display("FAIL bp_beat[%0d] got %h/%h want %h/%h", i,
                 beats[i].sx, beats[i].sy, exp.sx, exp.sy);
      end
    end
    checks++;
    if (stall_errs != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes while stalled want 0", stall_errs);
    end
    checks++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_end got frames=%0d busy=%b want 1 0", frame_count, busy);
    end
  endtask

  task automatic test_credits();
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    repeat (10) step();
    checks++;
    if (beats.size() != 2 || out_valid !== 1'b0 || inflight !== CW'(2)) begin
      errors++;
      $display("FAIL credit_block got xfers=%0d valid=%b inflight=%0d want 2 0 2",
               beats.size(), out_valid, inflight);
    end
    ret_man = 1'b1;
    step();
    checks++;
    if (inflight !== CW'(1) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_return got inflight=%0d valid=%b want 1 1", inflight, out_valid);
    end
    step();
    checks++;
    if (inflight !== CW'(1) || out_valid !== 1'b1 || beats.size() != 3) begin
      errors++;
      $display("FAIL credit_same_cycle got inflight=%0d valid=%b xfers=%0d want 1 1 3",
               inflight, out_valid, beats.size());
    end
    ret_man = 1'b0;
    step();
    checks++;
    if (inflight !== CW'(2) || out_valid !== 1'b0 || beats.size() != 4) begin
      errors++;
      $display("FAIL credit_reblock got inflight=%0d valid=%b xfers=%0d want 2 0 4",
               inflight, out_valid, beats.size());
    end
    auto_en = 1'b1;
    ret_man = 1'b1;
    step();
    step();
    ret_man = 1'b0;
    run_until_idle(300, 1'b0);
    checks++;
    if (beats.size() != H * V || frame_count !== 16'd1 || err_underflow !== 1'b0 ||
        inflight !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL credit_end got xfers=%0d frames=%0d err=%b inflight=%0d busy=%b want 12 1 0 0 0",
               beats.size(), frame_count, err_underflow, inflight, busy);
    end
  endtask

  task automatic test_abort();
    do_reset();
    auto_en = 1'b1; out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 100 && beats.size() < 4; i++) step();
    out_ready = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
    checks++;
    if (out_valid !== 1'b1 || screen_x !== 32'h0 || screen_y !== 32'h0020_0000 ||
        beats.size() != 4) begin
      errors++;
      $display("FAIL abort_setup got valid=%b x=%h y=%h xfers=%0d want 1 0 00200000 4",
               out_valid, screen_x, screen_y, beats.size());
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_drop got valid=%b busy=%b want 0 1", out_valid, busy);
    end
    out_ready = 1'b1;
    run_until_idle(100, 1'b0);
    checks++;
    if (beats.size() != 4 || done_pulses != 1 || frame_count !== 16'd1 ||
        inflight !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_end got xfers=%0d done=%0d frames=%0d inflight=%0d busy=%b want 4 1 1 0 0",
               beats.size(), done_pulses, frame_count, inflight, busy);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    auto_en = 1'b1; out_ready = 1'b1; continuous = 1'b1;
    pulse_start();
    for (int i = 0; i < 600 && beats.size() < 26; i++) step();
    continuous = 1'b0;
    run_until_idle(400, 1'b0);
    checks++;
    if (beats.size() != 3 * H * V) begin
      errors++;
      $display("FAIL cont_count got %0d want %0d", beats.size(), 3 * H * V);
    end
    for (int i = 0; i < beats.size(); i++) begin
      checks++;
      if (beats[i].sof !== ((i % (H * V)) == 0) || beats[i].sx !== (32'(i % H) << FPF)) begin
        errors++;
        $display("FAIL cont_beat[%0d] got sof=%b x=%h want sof=%b x=%h", i,
                 beats[i].sof, beats[i].sx, (i % (H * V)) == 0, 32'(i % H) << FPF);
      end
    end
    checks++;
    if (frame_count !== 16'd3 || done_pulses != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_end got frames=%0d done=%0d busy=%b want 3 3 0",
               frame_count, done_pulses, busy);
    end
  endtask

  task automatic test_reset_mid();
    auto_en = 1'b0; out_ready = 1'b1; continuous = 1'b0;
    pulse_start();
    for (int i = 0; i < 20 && inflight !== CW'(2); i++) step();
    checks++;
    if (inflight !== CW'(2) || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got inflight=%0d busy=%b want 2 1", inflight, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sof, eol, busy, frame_done, err_underflow} !== 6'b0 ||
        inflight !== '0 || frame_count !== 16'd0 || screen_x !== '0 || screen_y !== '0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b inflight=%0d frames=%0d x=%h y=%h want all 0",
               {out_valid, sof, eol, busy, frame_done, err_underflow},
               inflight, frame_count, screen_x, screen_y);
    end
    step();
    rst = 1'b0;
    ret_man = 1'b1;
    step();
    ret_man = 1'b0;
    checks++;
    if (err_underflow !== 1'b1 || inflight !== '0) begin
      errors++;
      $display("FAIL underflow got err=%b inflight=%0d want 1 0", err_underflow, inflight);
    end
    step();
    checks++;
    if (err_underflow !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL underflow_sticky got err=%b busy=%b want 1 0", err_underflow, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_credits();
    test_abort();
    test_continuous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_scan_seq.md
Name: pixel_scan_seq

Overview:
Parametrised pixel-coordinate sequencer that replaces bench-driven stimulus for the ray marcher. It raster-scans an H_RES x V_RES frame and emits Q11.21 screen_x/screen_y on a valid/ready stream into fullModule. A credit counter, fed by the pipeline's valid_out return, limits outstanding pixels to MAX_INFLIGHT. It supports single-frame and continuous modes, abort with drain, and frame/line markers for the downstream framebuffer writer.

Parameters:
H_RES, 640, pixels per line (>=2)
V_RES, 480, lines per frame (>=2)
MAX_INFLIGHT, 16, max issued-but-not-returned pixels (>=1)
FP_W, 32, width of fp coordinate outputs
FP_FRAC, 21, fractional bits of screen coordinates (Q11.21)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
start  in  1  single-cycle pulse; begins a frame when IDLE, ignored otherwise
continuous  in  1  sampled at end of drain; 1 = start next frame automatically
abort  in  1  pulse; stop issuing, drain in-flight pixels
out_valid  out  1  coordinate beat valid
out_ready  in  1  downstream accepts beat
screen_x  out  FP_W  x << FP_FRAC (fp)
screen_y  out  FP_W  y << FP_FRAC (fp)
sof  out  1  beat is pixel (0,0)
eol  out  1  beat is x == H_RES-1
ret_valid  in  1  one pixel result returned (fullModule valid_out)
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse when a frame (or aborted frame) fully drained
inflight  out  $clog2(MAX_INFLIGHT+1)  current credit usage
frame_count  out  16  completed frames, wraps at 65535 -> 0
err_underflow  out  1  sticky; ret_valid seen with inflight == 0

Behaviour:
- Reset: state IDLE; x=y=0; all outputs 0 (out_valid, sof, eol, busy, frame_done, inflight, frame_count, err_underflow, screen_x, screen_y). Reset mid-frame discards all state; returns arriving afterward with inflight==0 set err_underflow.
- FSM: IDLE -> SCAN on start. SCAN -> DRAIN on acceptance of the last pixel (H_RES-1, V_RES-1) or on abort. DRAIN -> (inflight==0) frame_done pulse, frame_count+1; then SCAN with x=y=0 if continuous==1, else IDLE.
- Latency: start at edge N -> out_valid=1 with (0,0) and sof=1 registered at N+1.
- Handshake: beat transfers when out_valid && out_ready. In SCAN, out_valid rises only if inflight < MAX_INFLIGHT. Once high, out_valid and the data stay stable until accepted; credit is consumed on acceptance. Exception: abort drops out_valid on the next edge. The unaccepted beat is discarded and not counted.
- Advance: on transfer x++. At x==H_RES-1, x=0 and y++. Next beat is presented the cycle after transfer (back-to-back at 1 pixel/clk when credits allow).
- Credits: inflight +1 on transfer, -1 on ret_valid; both in the same cycle leaves it unchanged. A ret_valid at 0 holds inflight at 0 and sets err_underflow (cleared only by rst).
- Coordinates: integer counters zero-extended and shifted left FP_FRAC; no rounding. Requires H_RES-1 and V_RES-1 < 2^(FP_W-FP_FRAC-1).
- start during SCAN/DRAIN is ignored. abort in IDLE is ignored. abort in DRAIN has no extra effect.
- Continuous with abort: the drained frame counts in frame_count (frame_done pulses). The restart decision is taken from continuous at drain completion.
- busy=1 in SCAN and DRAIN, including the frame_done cycle.

Decomposition:
- fp typedef and FP_FRAC constant live in common_defs.svh. Add a shared scan_state_t enum (IDLE, SCAN, DRAIN) to vector_pkg for reuse by the framebuffer writer.
- One sub-module: credit_counter (up/down saturating counter with underflow flag, parametrised MAX).

Test Plan:
- H_RES=4, V_RES=3, MAX_INFLIGHT=2, out_ready=1, ret_valid 5 cycles after each transfer, start pulse -> 12 beats in raster order (0,0)..(3,2). screen_x for x=3 is 0x00600000. sof only on first beat; eol on x=3 beats. frame_done once after the last return; frame_count=1; then IDLE.
- Same config, out_ready toggled 1/0 each cycle -> coordinates held stable while stalled; no duplicated or skipped pixels; 12 transfers total.
- ret_valid withheld -> exactly 2 transfers, then out_valid stays 0 with inflight=2. One return reissues exactly one beat. Transfer and return in the same cycle -> inflight unchanged.
- abort at 5th pixel while out_valid=1 and out_ready=0 -> out_valid 0 next cycle; that beat is never transferred. frame_done pulses after outstanding returns; frame_count=1.
- continuous=1 over 3 frames -> sof recurs every 12 transfers; frame_count=3. Drop continuous during frame 3 -> IDLE after its drain.
- rst asserted mid-SCAN with inflight=2 -> all outputs 0 asynchronously. Later ret_valid -> err_underflow=1, inflight stays 0.
